muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request a mult/multu/div/divu operation; sampled only in IDLE.
REQ-005 op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 opa  in  32  rs operand (multiplicand / dividend).
REQ-007 opb  in  32  rt operand (multiplier / divisor).
REQ-008 flush  in  1  abort any in-flight operation (pipeline flush).
REQ-009 hi_we  in  1  mthi write strobe.
REQ-010 lo_we  in  1  mtlo write strobe.
REQ-011 wdata  in  32  mthi/mtlo write data.
REQ-012 busy  out  1  registered; high while an operation is in flight; drives the pipeline stall.
REQ-013 done  out  1  registered one-cycle pulse; HI/LO already hold the new result in that cycle.
REQ-014 hi  out  32  HI register, readable every cycle (mfhi).
REQ-015 lo  out  32  LO register, readable every cycle (mflo).

Function
REQ-016 The FSM SHALL use states IDLE, MUL, DIV, FIX and DONE.
REQ-017 Accept cycle T is an IDLE cycle with start=1 and flush=0; operands and op SHALL be latched at the end of T.
REQ-018 Transitions from IDLE on accept: op 0x goes to MUL; op 1x with opb!=0 goes to DIV; op 1x with opb==0 goes to FIX.
REQ-019 MUL lasts 1 cycle: the full 64-bit product is written (HI=[63:32], LO=[31:0]), then the FSM goes to DONE.
REQ-020 mult SHALL treat operands as two's complement; multu SHALL treat them as unsigned.
REQ-021 DIV SHALL run exactly 32 restoring-division iterations on operand magnitudes, one per cycle, counted by a 5-bit counter; the FSM then goes to FIX.
REQ-022 FIX writes the result and then goes to DONE:
  - div: quotient sign = sign(opa) XOR sign(opb); remainder sign = sign(opa).
  - divu: unsigned quotient and remainder.
  - LO = quotient, HI = remainder.
REQ-023 Divide-by-zero (opb==0, div or divu) SHALL write HI=opa and LO=0xFFFFFFFF in FIX.
REQ-024 Latency: done=1 in cycle T+2 for mult, multu and divide-by-zero; in cycle T+34 for div and divu.
REQ-025 DONE lasts 1 cycle with done=1, then the FSM returns to IDLE.
REQ-026 busy SHALL be 1 from cycle T+1 through the done cycle inclusive, and 0 in IDLE.
REQ-027 start SHALL be ignored while busy=1; no queuing.
REQ-028 Signed edge case: div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (wrap, no trap).
REQ-029 In IDLE, hi_we/lo_we SHALL write wdata to HI/LO.
REQ-030 Both strobes together SHALL write both registers.
REQ-031 hi_we/lo_we SHALL be ignored while busy=1.
REQ-032 On simultaneous start and hi_we/lo_we in IDLE, start wins and the writes are dropped.
REQ-033 flush=1 in any state SHALL:
  - force IDLE next cycle;
  - leave HI/LO unchanged;
  - suppress done;
  - block acceptance of start in the same cycle.
REQ-034 A flush in the FIX cycle SHALL cancel the HI/LO write.

Reset
REQ-035 Asserting rst (low), at any time including mid-operation, SHALL immediately set: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter 0, latched operands 0.
REQ-036 After rst deassertion, the first rising edge SHALL be able to accept start.

Verification
REQ-037 mult, opa=0xFFFFFFFD (-3), opb=5 -> at T+2: done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-038 multu, opa=opb=0xFFFFFFFF -> at T+2: HI=0xFFFFFFFE, LO=0x00000001; busy high at T+1..T+2.
REQ-039 div, opa=0xFFFFFFF9 (-7), opb=2 -> at T+34: LO=0xFFFFFFFD, HI=0xFFFFFFFF; start pulsed at T+5 is ignored.
REQ-040 divu, opa=100, opb=0 -> at T+2: HI=0x00000064, LO=0xFFFFFFFF.
REQ-041 divu 50/7 with flush at T+10 -> busy=0 at T+11; HI/LO keep prior values; no done; new start at T+11 is accepted.
REQ-042 rst asserted at T+20 of a div -> outputs zero asynchronously; after release, mtlo wdata=0x1234 -> lo=0x1234 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: request, mthi/mtlo and result bundle for the HI/LO unit.
// master = pipeline side, slave = muldiv unit.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opa, opb, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide unit.
// Single-cycle multiply, 32-step restoring divide, mthi/mtlo writes.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [4:0]       cnt;
    logic             uns;
    logic             busyReg;
    logic             doneReg;

    logic             sgnA;
    logic             sgnB;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quoOut;
    logic [WIDTH-1:0] remOut;

    // Only div (op 10) treats operands as signed; mult signedness comes from uns.
    assign sgnA = ~bus.op[0] & bus.opa[WIDTH-1];
    assign sgnB = ~bus.op[0] & bus.opb[WIDTH-1];
    assign absA = sgnA ? -bus.opa : bus.opa;
    assign absB = sgnB ? -bus.opb : bus.opb;

    assign prod = {{WIDTH{~uns & aReg[WIDTH-1]}}, aReg}
                * {{WIDTH{~uns & bReg[WIDTH-1]}}, bReg};

    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr};

    assign quoOut = (~uns & (aReg[WIDTH-1] ^ bReg[WIDTH-1])) ? -quo : quo;
    assign remOut = (~uns & aReg[WIDTH-1]) ? -rem : rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            hiReg   <= '0;
            loReg   <= '0;
            aReg    <= '0;
            bReg    <= '0;
            dvsr    <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            uns     <= 1'b0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        aReg    <= bus.opa;
                        bReg    <= bus.opb;
                        uns     <= bus.op[0];
                        rem     <= '0;
                        quo     <= absA;
                        dvsr    <= absB;
                        cnt     <= '0;
                        busyReg <= 1'b1;
                        if (!bus.op[1])
                            state <= MUL;
                        else if (bus.opb != '0)
                            state <= DIV;
                        else
                            state <= FIX;
                    end else begin
                        if (bus.hi_we)
                            hiReg <= bus.wdata;
                        if (bus.lo_we)
                            loReg <= bus.wdata;
                    end
                end
                MUL: begin
                    {hiReg, loReg} <= prod;
                    doneReg        <= 1'b1;
                    state          <= DONE;
                end
                DIV: begin
                    // Restore by keeping the shifted remainder when the trial goes negative.
                    rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    if (bReg == '0) begin
                        hiReg <= aReg;
                        loReg <= '1;
                    end else begin
                        hiReg <= remOut;
                        loReg <= quoOut;
                    end
                    doneReg <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busyReg;
    assign bus.done = doneReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table, directed corner sequences and random ops
// checked against an arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;
    logic clk;
    logic rst;
    int   vecs;
    int   errs;
    logic [31:0] mHi;
    logic [31:0] mLo;

    muldiv_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void refModel(input logic [1:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        h = '0;
        l = '0;
        if (op[1] && b == 0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else begin
            case (op)
                2'b00: begin
                    p = sa * sb;
                    {h, l} = p;
                end
                2'b01: begin
                    p = ua * ub;
                    {h, l} = p;
                end
                2'b10: begin
                    sq = sa / sb;
                    sr = sa % sb;
                    l = sq[31:0];
                    h = sr[31:0];
                end
                default: begin
                    p = ua / ub;
                    l = p[31:0];
                    p = ua % ub;
                    h = p[31:0];
                end
            endcase
        end
    endfunction

    task automatic runOp(input string nm, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eHi, input logic [31:0] eLo,
                         input int eLat, input int pokeAt);
        int n;
        bit drop;
        drop = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        step();
        bus.start = 1'b0;
        bus.opa   = $urandom;
        bus.opb   = $urandom;
        n = 1;
        check({nm, " busyT1"}, bus.busy, 1);
        while (!bus.done && n < 40) begin
            if (!bus.busy)
                drop = 1'b1;
            if (n == pokeAt) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
            end
            step();
            bus.start = 1'b0;
            n++;
        end
        check({nm, " busyHeld"}, drop, 0);
        check({nm, " latency"}, n, eLat);
        check({nm, " busyAtDone"}, bus.busy, 1);
        check({nm, " hi"}, bus.hi, eHi);
        check({nm, " lo"}, bus.lo, eLo);
        mHi = eHi;
        mLo = eLo;
        step();
        check({nm, " idleBusy"}, bus.busy, 0);
        check({nm, " donePulse"}, bus.done, 0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;

        tbl[0] = '{2'b00, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 2};
        tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
        tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        tbl[3] = '{2'b11, 32'd100,       32'h0,         32'h0000_0064, 32'hFFFF_FFFF, 2};
        tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 34};
        tbl[5] = '{2'b11, 32'd50,        32'd7,         32'd1,         32'd7,         34};
        tbl[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
        tbl[7] = '{2'b10, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 2};
        tbl[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         2};
        tbl[9] = '{2'b11, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF, 34};

        vecs = 0;
        errs = 0;
        mHi = '0;
        mLo = '0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = '0;
        bus.opb   = '0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        #2;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst hi", bus.hi, 0);
        check("rst lo", bus.lo, 0);
        #10;
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            runOp($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].hi, tbl[i].lo, tbl[i].lat, -1);

        // start pulsed mid-divide must be ignored
        runOp("divPoke", 2'b10, 32'hFFFF_FFF9, 32'h2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 5);

        // start together with mthi/mtlo: start wins, strobes held through busy
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        runOp("startWins", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 2, -1);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;

        // both strobes write both registers
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        step();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        mHi = 32'h0000_AAAA;
        mLo = 32'h0000_AAAA;
        check("mtBoth hi", bus.hi, mHi);
        check("mtBoth lo", bus.lo, mLo);

        // flush during divide at T+10
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.opa   = 32'd50;
        bus.opb   = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flushDiv busy", bus.busy, 0);
        check("flushDiv done", bus.done, 0);
        check("flushDiv hi", bus.hi, mHi);
        check("flushDiv lo", bus.lo, mLo);
        runOp("afterFlush", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 2, -1);

        // flush blocks same-cycle start
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.flush = 1'b1;
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flushIdle busy", bus.busy, 0);
        step();
        check("flushIdle done", bus.done, 0);

        // flush in FIX cancels the HI/LO write
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.opa   = 32'd50;
        bus.opb   = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (32) step();
        check("fix busy", bus.busy, 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flushFix busy", bus.busy, 0);
        check("flushFix done", bus.done, 0);
        check("flushFix hi", bus.hi, mHi);
        check("flushFix lo", bus.lo, mLo);
        step();
        check("flushFix noDone", bus.done, 0);

        // async reset in the middle of a divide
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.opa   = 32'h1234_5678;
        bus.opb   = 32'd3;
        step();
        bus.start = 1'b0;
        repeat (19) step();
        #2;
        rst = 1'b0;
        #1;
        check("midRst busy", bus.busy, 0);
        check("midRst done", bus.done, 0);
        check("midRst hi", bus.hi, 0);
        check("midRst lo", bus.lo, 0);
        #2;
        rst = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        step();
        bus.lo_we = 1'b0;
        mHi = '0;
        mLo = 32'h0000_1234;
        check("postRst lo", bus.lo, mLo);
        check("postRst hi", bus.hi, mHi);
        runOp("postRstDiv", 2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 34, -1);

        // random ops and mthi/mtlo writes against the reference model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.hi_we = 1'($urandom_range(0, 1));
                bus.lo_we = 1'($urandom_range(0, 1));
                bus.wdata = $urandom;
                if (bus.hi_we)
                    mHi = bus.wdata;
                if (bus.lo_we)
                    mLo = bus.wdata;
                step();
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
                check($sformatf("rndMt%0d hi", i), bus.hi, mHi);
                check($sformatf("rndMt%0d lo", i), bus.lo, mLo);
            end else begin
                rop = 2'($urandom_range(0, 3));
                ra  = $urandom >> $urandom_range(0, 31);
                rb  = ($urandom_range(0, 7) == 0) ? 32'd0
                                                  : ($urandom >> $urandom_range(0, 31));
                refModel(rop, ra, rb, eh, el);
                runOp($sformatf("rnd%0d", i), rop, ra, rb, eh, el,
                      (rop[1] && rb != 0) ? 34 : 2, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
